four_to_two_pe: RTL and testbench
=================================

// Module: four_to_two_pe
// PURPOSE
//   Registered 4-to-2 priority encoder. Encodes the index of the highest-priority
//   asserted request among four single-bit inputs into a 2-bit code {a,b}.
//   Flags whether any request is present. Used as a small arbitration/index
//   primitive feeding downstream synchronous logic.
// PARAMETERS
//   REG_OUT   1   1: outputs registered on clk (1-cycle latency); 0: outputs combinational (reset ignored)
// PORTS
//   clk   in   1   single clock, rising-edge active
//   rst   in   1   synchronous, active-high reset
//   p     in   1   request 0 (lowest priority)
//   q     in   1   request 1
//   r     in   1   request 2
//   s     in   1   request 3 (highest priority)
//   a     out  1   encoded index MSB
//   b     out  1   encoded index LSB
//   v     out  1   valid: at least one of p,q,r,s asserted
// BEHAVIOUR
//   - Priority s > r > q > p; lower-priority inputs are don't-care once a higher one is 1.
//   - Encoding {a,b}: s=1 -> 11; else r=1 -> 10; else q=1 -> 01; else p=1 -> 00.
//   - No request (p=q=r=s=0): {a,b}=00, v=0; distinguishes from p-only case (00, v=1).
//   - Equations: a = s|r; b = s|(~r&q); v = p|q|r|s.
//   - REG_OUT=1: a,b,v sampled from inputs at each rising clk edge; 1-cycle latency;
//     outputs stable between edges; input glitches between edges not visible.
//   - Reset (REG_OUT=1): rst=1 at a rising edge forces a=0,b=0,v=0 on that edge,
//     regardless of inputs; reset has priority over encoding. Asserted mid-operation,
//     it clears outputs at the next edge; first edge with rst=0 loads encoded inputs.
//   - REG_OUT=0: a,b,v purely combinational from inputs; zero latency; clk/rst unused.
//   - No internal state other than the output registers; no handshake.
//   - Inputs X/Z not handled; caller drives known values.
// TESTING
//   - rst=1 for 2 edges, inputs p=q=r=s=1 -> a=0,b=0,v=0 throughout reset.
//   - p=1,q=1,r=0,s=0 -> after 1 edge {a,b}=01, v=1 (q beats p).
//   - p=0,q=1,r=1,s=0 -> {a,b}=10, v=1; then p=1,q=0,r=0,s=1 -> {a,b}=11, v=1.
//   - p=q=r=s=1 -> {a,b}=11, v=1; then p=0,q=1,r=0,s=0 -> {a,b}=01 one edge later.
//   - p=1 only -> {a,b}=00, v=1; all zero -> {a,b}=00, v=0.
//   - Assert rst mid-stream with s=1 -> outputs 00/v=0 at that edge; release -> 11/v=1 next edge.

Source files
------------

// File: rtl/four_to_two_pe_if.sv
// Bus bundle for the 4-to-2 priority encoder: four request lines in, encoded index and valid out.
// The master drives the requests; the encoder (slave) returns the code.
interface four_to_two_pe_if;
  logic p;
  logic q;
  logic r;
  logic s;
  logic a;
  logic b;
  logic v;

  modport master (
    output p, q, r, s,
    input  a, b, v
  );

  modport slave (
    input  p, q, r, s,
    output a, b, v
  );
endinterface

// File: rtl/four_to_two_pe.sv
// 4-to-2 priority encoder (s > r > q > p) with a request-present flag.
// With REG_OUT=1 the result is registered with one cycle of latency; with REG_OUT=0 it is combinational.
module four_to_two_pe #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  four_to_two_pe_if.slave   bus
);

  // Returns {a, b, v} for a request vector ordered {s, r, q, p}.
  function automatic logic [2:0] encode_f(input logic [3:0] req);
    logic [2:0] res;
    res = 3'b000;
    if (req[3]) begin
      res = 3'b111;
    end else if (req[2]) begin
      res = 3'b101;
    end else if (req[1]) begin
      res = 3'b011;
    end else if (req[0]) begin
      res = 3'b001;
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  logic [3:0] req_s;
  logic [2:0] enc_s;

  // Gather requests and encode them.
  always_comb begin
    req_s = {bus.s, bus.r, bus.q, bus.p};
    enc_s = encode_f(req_s);
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [2:0] out_r;

      // Output register; reset wins over the encoded value.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_r <= 3'b000;
        end else begin
          out_r <= enc_s;
        end
      end

      assign bus.a = out_r[2];
      assign bus.b = out_r[1];
      assign bus.v = out_r[0];
    end else begin : g_comb
      // Clock and reset have no effect in the combinational build.
      logic unused_s;
      assign unused_s = clk ^ rst;

      assign bus.a = enc_s[2];
      assign bus.b = enc_s[1];
      assign bus.v = enc_s[0];
    end
  endgenerate

endmodule

// File: tb/tb_four_to_two_pe.sv
// Randomised scoreboard bench for four_to_two_pe: registered build checked by a monitor,
// combinational build checked directly after each input change.
module tb_four_to_two_pe;

  logic clk;
  logic rst;

  four_to_two_pe_if reg_if ();
  four_to_two_pe_if comb_if ();

  four_to_two_pe #(.REG_OUT(1'b1)) dut_reg (
    .clk (clk),
    .rst (rst),
    .bus (reg_if.slave)
  );

  four_to_two_pe #(.REG_OUT(1'b0)) dut_comb (
    .clk (clk),
    .rst (rst),
    .bus (comb_if.slave)
  );

  int n_cmp;
  int n_bad;
  logic [2:0] exp_q[$];
  bit driver_done;

  // Reference: index of the highest set request bit, valid if any bit set.
  function automatic logic [2:0] model(input bit rst_in, input logic [3:0] req);
    int idx;
    bit found;
    logic [1:0] code;
    idx = 0;
    found = 1'b0;
    if (rst_in) return 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        idx = i;
        found = 1'b1;
      end
    end
    code = idx[1:0];
    return {code, found};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors {rst, s, r, q, p}.
  logic [4:0] dir_tab [0:12];
  initial begin
    dir_tab[0]  = 5'b1_1111;
    dir_tab[1]  = 5'b1_1111;
    dir_tab[2]  = 5'b0_0011;
    dir_tab[3]  = 5'b0_0110;
    dir_tab[4]  = 5'b0_1001;
    dir_tab[5]  = 5'b0_1111;
    dir_tab[6]  = 5'b0_0010;
    dir_tab[7]  = 5'b0_0001;
    dir_tab[8]  = 5'b0_0000;
    dir_tab[9]  = 5'b0_1000;
    dir_tab[10] = 5'b1_1000;
    dir_tab[11] = 5'b0_1000;
    dir_tab[12] = 5'b0_0100;
  end

  task automatic apply(input logic [4:0] vec);
    logic [2:0] cexp;
    logic [2:0] cact;
    @(negedge clk);
    rst = vec[4];
    reg_if.s = vec[3];  reg_if.r = vec[2];  reg_if.q = vec[1];  reg_if.p = vec[0];
    comb_if.s = vec[3]; comb_if.r = vec[2]; comb_if.q = vec[1]; comb_if.p = vec[0];
    exp_q.push_back(model(vec[4], vec[3:0]));
    #1;
    cexp = model(1'b0, vec[3:0]);
    cact = {comb_if.a, comb_if.b, comb_if.v};
    n_cmp++;
    if (cact !== cexp) begin
      n_bad++;
      $display("FAIL comb_enc req=%b got {a,b,v}=%b expected %b", vec[3:0], cact, cexp);
    end
  endtask

  // Monitor: one registered result appears after every rising edge.
  initial begin
    logic [2:0] e;
    logic [2:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {reg_if.a, reg_if.b, reg_if.v};
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL reg_enc t=%0t got {a,b,v}=%b expected %b", $time, got, e);
        end
      end
    end
  end

  // Stimulus driver and end-of-run summary.
  initial begin
    logic [4:0] vec;
    n_cmp = 0;
    n_bad = 0;
    driver_done = 1'b0;
    rst = 1'b1;
    reg_if.p = 1'b0;  reg_if.q = 1'b0;  reg_if.r = 1'b0;  reg_if.s = 1'b0;
    comb_if.p = 1'b0; comb_if.q = 1'b0; comb_if.r = 1'b0; comb_if.s = 1'b0;
    for (int i = 0; i < 13; i++) apply(dir_tab[i]);
    for (int i = 0; i < 300; i++) begin
      vec[3:0] = 4'($urandom_range(0, 15));
      vec[4] = ($urandom_range(0, 15) == 0);
      apply(vec);
    end
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d required 0", exp_q.size());
    end
    driver_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog bound on the whole run.
  initial begin
    #50000;
    if (!driver_done) begin
      $display("FAIL timeout run did not complete, compared=%0d", n_cmp);
      $fatal(1);
    end
  end

endmodule
